// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 sequencer: state codes, lcd_in field
// positions and default timing (in clk_50 cycles).
package lcd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP_H = 3'd1;
    localparam state_t ST_EH_HI   = 3'd2;
    localparam state_t ST_EH_LO   = 3'd3;
    localparam state_t ST_SETUP_L = 3'd4;
    localparam state_t ST_EL_HI   = 3'd5;
    localparam state_t ST_EL_LO   = 3'd6;
    localparam state_t ST_WAIT    = 3'd7;

    localparam int RS_BIT   = 8;
    localparam int NIB_BIT  = 9;
    localparam int LONG_BIT = 10;

    localparam int T_SETUP_DEF  = 4;
    localparam int T_E_HIGH_DEF = 25;
    localparam int T_E_LOW_DEF  = 25;
    localparam int T_SHORT_DEF  = 2500;
    localparam int T_LONG_DEF   = 82000;
    localparam int T_TURN_DEF   = 50;
    localparam int DEBOUNCE_DEF = 500000;

    localparam int TIMER_W = 20;
    typedef logic [TIMER_W-1:0] timer_t;

    // The timer counts down to zero, so a dwell of N cycles is loaded as N-1.
    function automatic timer_t dwell(input int cycles);
        return timer_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Pad readback path: 2-flop synchroniser, bus-turnaround settle gate and a
// consecutive-sample debouncer for the five shared LCD pins.
module pb_debounce #(
    parameter int T_TURN   = 50,
    parameter int DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic [4:0] pads,
    output logic [4:0] pb
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int SET_W = $clog2(T_TURN + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(T_TURN);
    localparam logic [SET_W-1:0] SETTLE_ONE = 1;

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       candidate;
    logic [CNT_W-1:0] count;
    logic [SET_W-1:0] settle;
    logic             valid;

    // settle saturates at T_TURN, so equality is the same as >=
    assign valid = idle && (settle == SETTLE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            count     <= '0;
            settle    <= '0;
            pb        <= '0;
        end else begin
            sync1 <= pads;
            sync2 <= sync1;

            if (!idle)
                settle <= '0;
            else if (settle != SETTLE_MAX)
                settle <= settle + SETTLE_ONE;

            if (valid) begin
                if (sync2 != candidate) begin
                    candidate <= sync2;
                    count     <= '0;
                end else if (count == CNT_LAST) begin
                    pb <= candidate;
                end else begin
                    count <= count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_pb_controller.sv
// HD44780 4-bit write sequencer driven by the CPU lcd stream; between writes
// the shared pins are released and read back as five debounced push buttons.
module lcd_pb_controller
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_E_HIGH = T_E_HIGH_DEF,
    parameter int T_E_LOW  = T_E_LOW_DEF,
    parameter int T_SHORT  = T_SHORT_DEF,
    parameter int T_LONG   = T_LONG_DEF,
    parameter int T_TURN   = T_TURN_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lcd_in,
    input  logic        lcd_in_stb,
    output logic        lcd_in_ack,
    output logic [3:0]  lcd_data_out,
    output logic        lcd_rs_out,
    output logic        lcd_oe,
    output logic        lcd_e,
    input  logic [3:0]  lcd_data_in,
    input  logic        lcd_rs_in,
    output logic [4:0]  pb_out
);
    state_t     state;
    timer_t     timer;
    timer_t     wait_load;
    logic [3:0] low_nibble;
    logic       nibble_only;
    logic       long_delay;
    logic       accept;
    logic       expired;
    logic       unused_in;

    assign lcd_in_ack = (state == ST_IDLE);
    assign accept     = lcd_in_stb && lcd_in_ack;
    assign expired    = (timer == '0);
    assign wait_load  = long_delay ? dwell(T_LONG) : dwell(T_SHORT);
    assign unused_in  = &{1'b0, lcd_in[31:LONG_BIT+1]};

    // Data/rs only change on entry to SETUP states, never on an E edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            lcd_e        <= 1'b0;
            lcd_oe       <= 1'b0;
            lcd_data_out <= '0;
            lcd_rs_out   <= 1'b0;
            low_nibble   <= '0;
            nibble_only  <= 1'b0;
            long_delay   <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                state        <= ST_SETUP_H;
                timer        <= dwell(T_SETUP);
                lcd_oe       <= 1'b1;
                lcd_data_out <= lcd_in[7:4];
                low_nibble   <= lcd_in[3:0];
                lcd_rs_out   <= lcd_in[RS_BIT];
                nibble_only  <= lcd_in[NIB_BIT];
                long_delay   <= lcd_in[LONG_BIT];
            end
        end else if (!expired) begin
            timer <= timer - timer_t'(1);
        end else begin
            case (state)
                ST_SETUP_H: begin
                    state <= ST_EH_HI;
                    timer <= dwell(T_E_HIGH);
                    lcd_e <= 1'b1;
                end
                ST_EH_HI: begin
                    state <= ST_EH_LO;
                    timer <= dwell(T_E_LOW);
                    lcd_e <= 1'b0;
                end
                ST_EH_LO: begin
                    if (nibble_only) begin
                        state <= ST_WAIT;
                        timer <= wait_load;
                    end else begin
                        state        <= ST_SETUP_L;
                        timer        <= dwell(T_SETUP);
                        lcd_data_out <= low_nibble;
                    end
                end
                ST_SETUP_L: begin
                    state <= ST_EL_HI;
                    timer <= dwell(T_E_HIGH);
                    lcd_e <= 1'b1;
                end
                ST_EL_HI: begin
                    state <= ST_EL_LO;
                    timer <= dwell(T_E_LOW);
                    lcd_e <= 1'b0;
                end
                ST_EL_LO: begin
                    state <= ST_WAIT;
                    timer <= wait_load;
                end
                default: begin
                    state  <= ST_IDLE;
                    timer  <= '0;
                    lcd_oe <= 1'b0;
                end
            endcase
        end
    end

    pb_debounce #(
        .T_TURN   (T_TURN),
        .DEBOUNCE (DEBOUNCE)
    ) u_pb_debounce (
        .clk  (clk),
        .rst  (rst),
        .idle (lcd_in_ack),
        .pads ({lcd_rs_in, lcd_data_in}),
        .pb   (pb_out)
    );

endmodule

// File: tb/tb_lcd_pb_controller.sv
// Bench for lcd_pb_controller with short timing: directed scenarios plus a
// randomized run, all compared against a schedule-based reference model.
module tb_lcd_pb_controller;
    localparam int T_SETUP  = 2;
    localparam int T_E_HIGH = 3;
    localparam int T_E_LOW  = 3;
    localparam int T_SHORT  = 10;
    localparam int T_LONG   = 40;
    localparam int T_TURN   = 4;
    localparam int DEBOUNCE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lcd_in = '0;
    logic        lcd_in_stb = 1'b0;
    logic        lcd_in_ack;
    logic [3:0]  lcd_data_out;
    logic        lcd_rs_out;
    logic        lcd_oe;
    logic        lcd_e;
    logic [4:0]  pads = '0;
    logic [4:0]  pb_out;

    int vectors = 0;
    int errors  = 0;

    lcd_pb_controller #(
        .T_SETUP(T_SETUP), .T_E_HIGH(T_E_HIGH), .T_E_LOW(T_E_LOW), .T_SHORT(T_SHORT),
        .T_LONG(T_LONG), .T_TURN(T_TURN), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst(rst), .lcd_in(lcd_in), .lcd_in_stb(lcd_in_stb), .lcd_in_ack(lcd_in_ack),
        .lcd_data_out(lcd_data_out), .lcd_rs_out(lcd_rs_out), .lcd_oe(lcd_oe), .lcd_e(lcd_e),
        .lcd_data_in(pads[3:0]), .lcd_rs_in(pads[4]), .pb_out(pb_out)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted word becomes a per-cycle schedule of {e, rs, data}.
    logic [5:0] sched[$];
    logic       m_ack, m_e, m_oe, m_rs;
    logic [3:0] m_data;
    logic [4:0] m_pb, m_s1, m_s2, m_run_val;
    int         m_run_len, m_idle_age;

    task automatic enqueue_word(input logic [31:0] w);
        logic [3:0] hi, lo;
        logic       rs;
        hi = w[7:4];
        lo = w[3:0];
        rs = w[8];
        repeat (T_SETUP)  sched.push_back({1'b0, rs, hi});
        repeat (T_E_HIGH) sched.push_back({1'b1, rs, hi});
        repeat (T_E_LOW)  sched.push_back({1'b0, rs, hi});
        if (!w[9]) begin
            repeat (T_SETUP)  sched.push_back({1'b0, rs, lo});
            repeat (T_E_HIGH) sched.push_back({1'b1, rs, lo});
            repeat (T_E_LOW)  sched.push_back({1'b0, rs, lo});
        end
        repeat (w[10] ? T_LONG : T_SHORT) sched.push_back({1'b0, rs, w[9] ? hi : lo});
    endtask

    task automatic model_step();
        logic       was_idle;
        logic [4:0] smp;
        logic       smp_ok;
        if (rst) begin
            sched.delete();
            m_ack = 1'b1; m_e = 1'b0; m_oe = 1'b0; m_rs = 1'b0; m_data = '0;
            m_pb = '0; m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run_len = 1; m_idle_age = 0;
            return;
        end
        was_idle = m_ack;
        smp      = m_s2;
        smp_ok   = was_idle && (m_idle_age >= T_TURN);
        m_s2     = m_s1;
        m_s1     = pads;
        if (smp_ok) begin
            if (smp == m_run_val) begin
                if (m_run_len <= DEBOUNCE) m_run_len++;
            end else begin
                m_run_val = smp;
                m_run_len = 1;
            end
            if (m_run_len > DEBOUNCE) m_pb = m_run_val;
        end
        if (was_idle && lcd_in_stb) enqueue_word(lcd_in);
        if (sched.size() > 0) begin
            {m_e, m_rs, m_data} = sched.pop_front();
            m_oe  = 1'b1;
            m_ack = 1'b0;
        end else begin
            m_e   = 1'b0;
            m_oe  = 1'b0;
            m_ack = 1'b1;
        end
        m_idle_age = !m_ack ? 0 : (was_idle ? m_idle_age + 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [12:0] dut_vec();
        return {lcd_in_ack, lcd_e, lcd_oe, lcd_rs_out, lcd_data_out, pb_out};
    endfunction

    function automatic logic [12:0] mdl_vec();
        return {m_ack, m_e, m_oe, m_rs, m_data, m_pb};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            tick();
            vectors++;
            if (dut_vec() !== 13'b1_0_0_0_0000_00000) begin
                errors++;
                $display("FAIL reset_state: got %013b want %013b", dut_vec(), 13'b1_0_0_0_0000_00000);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write(input string tag, input logic [31:0] w, input int exp_lat,
                                     input int exp_pulses, input logic [7:0] exp_nibs);
        int         lat, pulses, e_cycles;
        logic [7:0] nibs;
        logic       prev_e;
        pulses = 0; e_cycles = 0; nibs = '0; prev_e = 1'b0;
        lcd_in = w;
        lcd_in_stb = 1'b1;
        tick();
        lcd_in_stb = 1'b0;
        lat = 1;
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL %s_cycle: dut %013b model %013b", tag, dut_vec(), mdl_vec());
        end
        while (!lcd_in_ack && lat < 200) begin
            if (lcd_e && !prev_e) begin
                pulses++;
                nibs = {nibs[3:0], lcd_data_out};
            end
            if (lcd_e) e_cycles++;
            prev_e = lcd_e;
            tick();
            lat++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL %s_cycle: dut %013b model %013b", tag, dut_vec(), mdl_vec());
            end
        end
        vectors++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", tag, lat, exp_lat);
        end
        vectors++;
        if (pulses != exp_pulses || e_cycles != exp_pulses * T_E_HIGH) begin
            errors++;
            $display("FAIL %s_pulses: got %0d/%0d want %0d/%0d", tag, pulses, e_cycles,
                     exp_pulses, exp_pulses * T_E_HIGH);
        end
        vectors++;
        if (nibs !== exp_nibs) begin
            errors++;
            $display("FAIL %s_nibbles: got %h want %h", tag, nibs, exp_nibs);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        lcd_in = 32'h401;
        lcd_in_stb = 1'b1;
        tick();
        lcd_in = 32'h0C6;
        lat = 1;
        while (!lcd_in_ack && lat < 200) begin
            tick();
            lat++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL b2b_cycle: dut %013b model %013b", dut_vec(), mdl_vec());
            end
        end
        vectors++;
        if (lat != 1 + 2 * (T_SETUP + T_E_HIGH + T_E_LOW) + T_LONG) begin
            errors++;
            $display("FAIL b2b_long_latency: got %0d want %0d", lat,
                     1 + 2 * (T_SETUP + T_E_HIGH + T_E_LOW) + T_LONG);
        end
        tick();
        lcd_in_stb = 1'b0;
        vectors++;
        if (lcd_in_ack !== 1'b0 || lcd_data_out !== 4'hC) begin
            errors++;
            $display("FAIL b2b_second_accept: ack %b data %h want ack 0 data c", lcd_in_ack, lcd_data_out);
        end
        lat = 1;
        while (!lcd_in_ack && lat < 200) begin
            tick();
            lat++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL b2b_cycle: dut %013b model %013b", dut_vec(), mdl_vec());
            end
        end
        vectors++;
        if (lat != 27) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d want 27", lat);
        end
    endtask

    task automatic test_debounce();
        int idle_cyc;
        pads = 5'b10110;
        lcd_in = 32'h230;
        lcd_in_stb = 1'b1;
        tick();
        lcd_in_stb = 1'b0;
        for (int i = 0; i < 100 && !lcd_in_ack; i++) tick();
        idle_cyc = 1;
        while (pb_out !== 5'b10110 && idle_cyc < 60) begin
            tick();
            idle_cyc++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL debounce_cycle: dut %013b model %013b", dut_vec(), mdl_vec());
            end
        end
        vectors++;
        if (idle_cyc != T_TURN + 2 + DEBOUNCE) begin
            errors++;
            $display("FAIL debounce_timing: pb in idle cycle %0d want %0d", idle_cyc, T_TURN + 2 + DEBOUNCE);
        end
        pads = 5'b00011;
        for (int i = 0; i < 13; i++) begin
            if (i == 6) pads = 5'b11111;
            if (i == 7) pads = 5'b00011;
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL glitch_cycle: dut %013b model %013b", dut_vec(), mdl_vec());
            end
        end
        vectors++;
        if (pb_out !== 5'b10110) begin
            errors++;
            $display("FAIL glitch_hold: got %05b want 10110", pb_out);
        end
        repeat (12) tick();
        vectors++;
        if (pb_out !== 5'b00011) begin
            errors++;
            $display("FAIL glitch_recover: got %05b want 00011", pb_out);
        end
    endtask

    task automatic test_freeze();
        int idle_cyc;
        pads = 5'b11100;
        repeat (5) tick();
        lcd_in = 32'h0A5;
        lcd_in_stb = 1'b1;
        tick();
        lcd_in_stb = 1'b0;
        for (int i = 0; i < 100 && !lcd_in_ack; i++) begin
            // while driven, the pads show the nibble the block is writing
            pads = lcd_oe ? {lcd_rs_out, lcd_data_out} : 5'b11100;
            vectors++;
            if (pb_out !== 5'b00011) begin
                errors++;
                $display("FAIL freeze_pb_hold: got %05b want 00011", pb_out);
            end
            tick();
        end
        pads = 5'b11100;
        idle_cyc = 1;
        while (pb_out !== 5'b11100 && idle_cyc < 60) begin
            tick();
            idle_cyc++;
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL freeze_cycle: dut %013b model %013b", dut_vec(), mdl_vec());
            end
        end
        // four samples were already counted before the write started
        vectors++;
        if (idle_cyc != T_TURN + 2 + DEBOUNCE - 4) begin
            errors++;
            $display("FAIL freeze_resume: pb in idle cycle %0d want %0d", idle_cyc, T_TURN + 2 + DEBOUNCE - 4);
        end
    endtask

    task automatic test_reset_mid_write();
        lcd_in = 32'h1FF;
        lcd_in_stb = 1'b1;
        tick();
        lcd_in_stb = 1'b0;
        repeat (T_SETUP) tick();
        vectors++;
        if (lcd_e !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_pulse: lcd_e %b want 1", lcd_e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (dut_vec() !== 13'b1_0_0_0_0000_00000) begin
            errors++;
            $display("FAIL midreset_state: got %013b want %013b", dut_vec(), 13'b1_0_0_0_0000_00000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(3) == 0) begin
                lcd_in_stb = ~lcd_in_stb;
                lcd_in = $urandom();
            end
            if ($urandom_range(39) == 0) pads = 5'($urandom());
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random_cycle %0d: dut %013b model %013b", i, dut_vec(), mdl_vec());
            end
        end
        lcd_in_stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write("write_rs", 32'h141, 27, 2, 8'h41);
        test_single_write("nibble_only", 32'h230, 19, 1, 8'h03);
        test_back_to_back();
        test_debounce();
        test_freeze();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
